// File: rtl/vga_fetch_pkg.sv
// Shared widths and FSM state encoding for the VGA frame fetcher.
package vga_fetch_pkg;

  localparam int ADDR_W  = 24;
  localparam int DATA_W  = 16;
  localparam int BURST_W = 10;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RECV,
    DRAIN
  } fetch_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush, occupancy level and registered read data.
module sync_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((level != LW'(DEPTH)) || do_pop);

  // NOTE: storage has no reset; the pointers and level alone define its contents.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      rd_data <= '0;
    end else begin
      // A pop on an empty FIFO returns zero rather than stale data.
      if (pop) rd_data <= empty ? '0 : mem[rd_ptr];
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
        level <= level + LW'(do_push) - LW'(do_pop);
      end
    end
  end

endmodule

// File: rtl/vga_fetch.sv
// Prefetches frame pixels from SDRAM in bursts into a pixel FIFO for the VGA scanout.
module vga_fetch
  import vga_fetch_pkg::*;
#(
  parameter int FIFO_DEPTH = 32,
  parameter int BURST_LEN  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [ADDR_W-1:0]  frame_words,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [BURST_W-1:0] mem_burst,
  input  logic               mem_ack,
  input  logic               mem_dvalid,
  input  logic [DATA_W-1:0]  mem_data,
  input  logic               pix_rd,
  output logic [DATA_W-1:0]  pix_data,
  output logic               pix_empty,
  output logic               underflow
);

  fetch_state_t               state;
  logic [ADDR_W-1:0]          next_addr;
  logic [ADDR_W-1:0]          remaining;
  logic [BURST_W-1:0]         beats;
  logic [BURST_W-1:0]         burst_len;
  logic [$clog2(FIFO_DEPTH):0] level;
  logic                       room_ok;
  logic                       last_beat;
  logic                       fifo_push;

  assign burst_len = (remaining >= ADDR_W'(BURST_LEN)) ? BURST_W'(BURST_LEN) : BURST_W'(remaining);
  // Space for a whole burst is reserved before asking, so pushes never meet a full FIFO.
  assign room_ok   = (32'(level) + 32'(beats)) <= 32'(FIFO_DEPTH - BURST_LEN);
  assign last_beat = mem_dvalid && (beats == BURST_W'(1));
  assign fifo_push = (state == RECV) && mem_dvalid && !frame_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_burst <= '0;
      next_addr <= '0;
      remaining <= '0;
      beats     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_start) begin
            next_addr <= base_addr;
            remaining <= frame_words;
          end else if ((remaining != '0) && room_ok) begin
            state     <= REQ;
            mem_req   <= 1'b1;
            mem_addr  <= next_addr;
            mem_burst <= burst_len;
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            beats   <= mem_burst;
            if (frame_start) begin
              // A granted burst must still be drained even though the frame restarted.
              state     <= DRAIN;
              next_addr <= base_addr;
              remaining <= frame_words;
            end else begin
              state     <= RECV;
              next_addr <= next_addr + ADDR_W'(mem_burst);
              remaining <= remaining - ADDR_W'(mem_burst);
            end
          end else if (frame_start) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            next_addr <= base_addr;
            remaining <= frame_words;
          end
        end
        RECV, DRAIN: begin
          if (mem_dvalid) beats <= beats - BURST_W'(1);
          if (frame_start) begin
            state     <= DRAIN;
            next_addr <= base_addr;
            remaining <= frame_words;
          end
          if (last_beat) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      underflow <= 1'b0;
    else if (frame_start)         underflow <= 1'b0;
    else if (pix_rd && pix_empty) underflow <= 1'b1;
  end

  // Old pixels are useless once a new frame begins, so the FIFO is flushed immediately.
  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (mem_data),
    .pop       (pix_rd),
    .flush     (frame_start),
    .rd_data   (pix_data),
    .level     (level),
    .empty     (pix_empty)
  );

endmodule
